// File: rtl/sm_clk_ctrl_pkg.sv
// Shared mode and FSM state codes for the CPU clock controller.
package sm_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } modeT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } stateT;

endpackage

// File: rtl/sm_clk_ctrl_sync.sv
// Multi-flop synchroniser for a group of asynchronous board inputs.
module sm_sync #(
  parameter int SIZE   = 1,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [STAGES-1:0][SIZE-1:0] pipe;

  // Shift the input through STAGES flops; oldest stage drives q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock controller: programmable half-period divider with HALT/RUN/STEP/BURST
// modes. clkOut is a plain register that only toggles on prescaler ticks.
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int DIV_W       = 5,
  parameter int BURST_W     = 16,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clkIn,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   divide,
  input  logic               stepReq,
  input  logic               burstStart,
  input  logic [BURST_W-1:0] burstLen,
  output logic               clkOut,
  output logic               busy,
  output logic [CNT_W-1:0]   cycleCnt
);

  logic [3:0]         ctrlS;
  logic [1:0]         modeS;
  logic               stepS, burstS, stepPrev, burstPrev, stepEdge, burstEdge;
  logic [DIV_W-1:0]   divS, divLat, preCnt;
  logic [BURST_W-1:0] lenS, remaining, remNext;
  logic               tick, rise, fall, riseOk;
  stateT              state, nextState;

  sm_sync #(.SIZE(4), .STAGES(SYNC_STAGES)) ctrlSync (
    .clk(clkIn), .rst_n(rst_n), .d({mode, stepReq, burstStart}), .q(ctrlS));
  sm_sync #(.SIZE(DIV_W), .STAGES(SYNC_STAGES)) divSync (
    .clk(clkIn), .rst_n(rst_n), .d(divide), .q(divS));
  sm_sync #(.SIZE(BURST_W), .STAGES(SYNC_STAGES)) lenSync (
    .clk(clkIn), .rst_n(rst_n), .d(burstLen), .q(lenS));

  assign modeS  = ctrlS[3:2];
  assign stepS  = ctrlS[1];
  assign burstS = ctrlS[0];

  // Previous synchronised button levels for rising-edge detection.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      stepPrev  <= 1'b0;
      burstPrev <= 1'b0;
    end else begin
      stepPrev  <= stepS;
      burstPrev <= burstS;
    end
  end

  assign stepEdge  = stepS & ~stepPrev;
  assign burstEdge = burstS & ~burstPrev;

  // Free-running prescaler; a new divide only takes effect at a tick so the
  // half-period in flight always completes with its old length.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      preCnt <= '0;
      divLat <= '0;
    end else if (tick) begin
      preCnt <= '0;
      divLat <= divS;
    end else begin
      preCnt <= preCnt + DIV_W'(1);
    end
  end

  assign tick   = (preCnt == divLat);
  assign riseOk = (state == ST_RUN) ||
                  (((state == ST_STEP) || (state == ST_BURST)) && (remaining != '0));
  assign rise   = tick & ~clkOut & riseOk;
  assign fall   = tick & clkOut;

  // Next-state logic. STEP reuses the burst counter with a length of one; a
  // burst abort just zeroes the counter and lets the normal exit path run.
  always_comb begin
    nextState = state;
    remNext   = remaining;
    case (state)
      ST_IDLE: begin
        if (modeS == MODE_RUN) begin
          nextState = ST_RUN;
        end else if ((modeS == MODE_STEP) && stepEdge) begin
          nextState = ST_STEP;
          remNext   = BURST_W'(1);
        end else if ((modeS == MODE_BURST) && burstEdge && (lenS != '0)) begin
          nextState = ST_BURST;
          remNext   = lenS;
        end
      end
      ST_RUN: begin
        if (modeS != MODE_RUN) nextState = ST_IDLE;
      end
      default: begin
        if (rise) remNext = remaining - BURST_W'(1);
        if ((state == ST_BURST) && (modeS != MODE_BURST)) remNext = '0;
        if ((remaining == '0) && (!clkOut || fall)) nextState = ST_IDLE;
      end
    endcase
  end

  // State, burst counter, clock output and delivered-cycle counter.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      clkOut    <= 1'b0;
      cycleCnt  <= '0;
    end else begin
      state     <= nextState;
      remaining <= remNext;
      busy      <= (nextState == ST_STEP) || (nextState == ST_BURST);
      if (rise)      clkOut <= 1'b1;
      else if (fall) clkOut <= 1'b0;
      if (rise) cycleCnt <= cycleCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Directed bench for sm_clk_ctrl: RUN period, STEP, BURST, HALT, divide change, reset.
module tb_sm_clk_ctrl;

  logic        clkIn = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  divide = '0;
  logic        stepReq = 1'b0;
  logic        burstStart = 1'b0;
  logic [15:0] burstLen = '0;
  logic        clkOut, busy;
  logic [31:0] cycleCnt;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state (sampled on the falling edge of clkIn).
  int   rises, run, lastHi, lastLo;
  logic prev, busySeen;

  sm_clk_ctrl dut (
    .clkIn(clkIn), .rst_n(rst_n), .mode(mode), .divide(divide),
    .stepReq(stepReq), .burstStart(burstStart), .burstLen(burstLen),
    .clkOut(clkOut), .busy(busy), .cycleCnt(cycleCnt));

  always #5 clkIn = ~clkIn;

  // Track rises and the length of the last completed high and low runs.
  always @(negedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      rises <= 0; run <= 0; lastHi <= 0; lastLo <= 0; prev <= 1'b0; busySeen <= 1'b0;
    end else begin
      if (clkOut !== prev) begin
        if (prev) lastHi <= run;
        else      lastLo <= run;
        run <= 1;
        if (clkOut) rises <= rises + 1;
      end else begin
        run <= run + 1;
      end
      prev <= clkOut;
      if (busy) busySeen <= 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clkIn);
    #1;
  endtask

  task automatic waitOut(input logic val, input int budget, input string tag);
    int n = 0;
    while (clkOut !== val && n < budget) begin step(1); n++; end
    check(tag, clkOut, val);
  endtask

  task automatic waitBusy(input logic val, input int budget, input string tag);
    int n = 0;
    while (busy !== val && n < budget) begin step(1); n++; end
    check(tag, busy, val);
  endtask

  task automatic doReset();
    mode = 2'b00; stepReq = 1'b0; burstStart = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic press(output logic sig);
    sig = 1'b1;
  endtask

  initial begin
    logic [31:0] c0;
    int r0, n;

    // Reset state
    step(2);
    check("rst_clkOut", clkOut, 0);
    check("rst_busy", busy, 0);
    check("rst_cycleCnt", cycleCnt, 0);
    rst_n = 1'b1;
    step(1);

    // RUN, divide=3: period 8, 4 high / 4 low, +2 rises per 16 cycles
    doReset();
    divide = 5'd3; mode = 2'b01;
    step(30);
    c0 = cycleCnt;
    step(16);
    check("run_cnt_delta", cycleCnt - c0, 2);
    check("run_hi_len", lastHi, 4);
    check("run_lo_len", lastLo, 4);
    check("run_busy_seen", busySeen, 0);

    // STEP, divide=0: one 1-cycle pulse from a 3-cycle press
    doReset();
    divide = 5'd0; mode = 2'b10;
    step(6);
    stepReq = 1'b1; step(3); stepReq = 1'b0;
    step(20);
    check("step_rises", rises, 1);
    check("step_hi_len", lastHi, 1);
    check("step_cycleCnt", cycleCnt, 1);
    check("step_busy_seen", busySeen, 1);
    check("step_busy_end", busy, 0);

    // STEP, divide=3: second press while busy is ignored
    divide = 5'd3;
    step(10);
    stepReq = 1'b1; step(3); stepReq = 1'b0; step(1);
    stepReq = 1'b1; step(3); stepReq = 1'b0;
    step(30);
    check("step2_rises", rises, 2);
    check("step2_hi_len", lastHi, 4);
    check("step2_busy", busy, 0);
    // press after busy cleared gives another pulse
    stepReq = 1'b1; step(3); stepReq = 1'b0;
    step(30);
    check("step3_rises", rises, 3);
    check("step3_cycleCnt", cycleCnt, 3);

    // BURST, burstLen=0: ignored
    doReset();
    divide = 5'd1; burstLen = 16'd0; mode = 2'b11;
    step(6);
    burstStart = 1'b1; step(2); burstStart = 1'b0;
    step(20);
    check("b0_rises", rises, 0);
    check("b0_busy_seen", busySeen, 0);
    check("b0_cycleCnt", cycleCnt, 0);

    // BURST, burstLen=5, divide=1: five rises at period 4, busy until 5th fall
    burstLen = 16'd5;
    step(4);
    burstStart = 1'b1; step(2); burstStart = 1'b0;
    waitBusy(1'b1, 10, "b5_busy_rise");
    waitBusy(1'b0, 60, "b5_busy_fall");
    check("b5_clk_at_end", clkOut, 0);
    check("b5_cycleCnt", cycleCnt, 5);
    settle();
    check("b5_rises", rises, 5);
    check("b5_hi_len", lastHi, 2);
    check("b5_lo_len", lastLo, 2);
    step(20);
    check("b5_no_extra", rises, 5);

    // RUN->HALT while high, divide=7: fall on schedule, then stays low
    doReset();
    divide = 5'd7; mode = 2'b01;
    waitOut(1'b1, 60, "halt_first_rise");
    c0 = cycleCnt;
    mode = 2'b00;
    waitOut(1'b0, 20, "halt_fall");
    settle();
    check("halt_hi_len", lastHi, 8);
    r0 = rises;
    step(40);
    check("halt_cycleCnt", cycleCnt, c0);
    check("halt_rises", rises, r0);
    check("halt_clkOut", clkOut, 0);

    // RUN, divide 7->1 mid high phase: current half 8, later halves 2
    doReset();
    divide = 5'd7; mode = 2'b01;
    waitOut(1'b1, 60, "div_first_rise");
    step(2);
    divide = 5'd1;
    waitOut(1'b0, 20, "div_fall");
    settle();
    check("div_old_hi", lastHi, 8);
    step(20);
    check("div_new_hi", lastHi, 2);
    check("div_new_lo", lastLo, 2);

    // Reset mid-burst with 3 rises remaining
    doReset();
    divide = 5'd1; burstLen = 16'd5; mode = 2'b11;
    step(6);
    burstStart = 1'b1; step(2); burstStart = 1'b0;
    n = 0;
    while (rises < 2 && n < 40) begin step(1); n++; end
    check("mid_two_rises", rises, 2);
    check("mid_clk_high", clkOut, 1);
    mode = 2'b00;
    rst_n = 1'b0;
    #1;
    check("mid_rst_clkOut", clkOut, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cycleCnt", cycleCnt, 0);
    step(2);
    rst_n = 1'b1;
    step(30);
    check("post_rst_rises", rises, 0);
    check("post_rst_cycleCnt", cycleCnt, 0);
    check("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
